ctrl_multiciclo: RTL and testbench

Multi-cycle control unit for the nRisc datapath, replacing the single-cycle opcode decoder. A registered FSM walks each instruction through FETCH/DECODE/EXEC/MEM/WB. It drives the existing datapath control lines with defined 0/1 values only, never z. It adds a data-memory ready handshake with timeout, illegal-opcode trapping, and a resumable HALT.

---
 rtl/nrisc_pkg.sv | 43 ++++
 rtl/ctrl_multiciclo.sv | 208 ++++++++++++++++++++
 tb/tb_ctrl_multiciclo.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/nrisc_pkg.sv
// Shared definitions for the nRisc multi-cycle control unit: opcodes,
// ALU operation codes, FSM state encoding and the datapath control bundle.
package nrisc_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_MOVE = 3'b001;
  localparam logic [2:0] OP_SLT  = 3'b010;
  localparam logic [2:0] OP_BEQ  = 3'b011;
  localparam logic [2:0] OP_JUMP = 3'b100;
  localparam logic [2:0] OP_SW   = 3'b101;
  localparam logic [2:0] OP_LW   = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam logic [1:0] ULA_ADD = 2'b00;
  localparam logic [1:0] ULA_SUB = 2'b01;
  localparam logic [1:0] ULA_SLT = 2'b10;

  typedef enum logic [2:0] {
    ST_START  = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  typedef struct packed {
    logic       ir_esc;
    logic       mem_to_reg;
    logic       esc_mem;
    logic       ler_mem;
    logic       branch;
    logic       ula_fonte;
    logic       esc_reg;
    logic       jump;
    logic       esc_pc;
    logic       move_reg;
    logic       reg_dest;
    logic [1:0] ula_op;
  } ctrl_t;

endpackage

// File: rtl/ctrl_multiciclo.sv
// Multi-cycle FSM control unit for the nRisc datapath; every output is
// registered from the next state and the (about to be) latched opcode.
module ctrl_multiciclo
  import nrisc_pkg::*;
#(
  parameter int unsigned OP_W        = 3,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic            Clock,
  input  logic            ResetN,
  input  logic [OP_W-1:0] OPcode,
  input  logic            MemReady,
  input  logic            Resume,
  output logic            MemToReg,
  output logic            EscMem,
  output logic            LerMem,
  output logic            Branch,
  output logic            ULAFonte,
  output logic            EscReg,
  output logic            Jump,
  output logic            EscPc,
  output logic            MoveReg,
  output logic            RegDest,
  output logic [1:0]      ULAOp,
  output logic            IREsc,
  output logic [2:0]      State,
  output logic            Halted,
  output logic            IllegalOp,
  output logic            MemErr
);

  state_e          state_q, state_d;
  logic [OP_W-1:0] op_q, op_d;
  logic            armed_q, armed_d;
  ctrl_t           ctrl_q, ctrl_d;
  logic            halted_q, halted_d;
  logic            illegal_q, illegal_d;
  logic            mem_err_q, mem_err_d;
  logic            timeout_hit;
  logic [2:0]      op3;
  logic            op_upper_nz;

  // The opcode is taken straight from the port on the DECODE edge so the
  // EXEC outputs registered on that same edge already see it.
  always_comb begin
    op_d = (state_q == ST_DECODE) ? OPcode : op_q;
  end

  assign op3         = op_d[2:0];
  assign op_upper_nz = (op_d >> 3) != '0;
  assign armed_d     = 1'b1;

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    mem_err_d = mem_err_q;
    case (state_q)
      ST_START:  if (armed_q) state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        if (op_upper_nz) begin
          state_d   = ST_HALT;
          illegal_d = 1'b1;
        end else if (op3 == OP_HALT) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (op3)
          OP_BEQ, OP_JUMP: state_d = ST_FETCH;
          OP_SW, OP_LW:    state_d = ST_MEM;
          default:         state_d = ST_WB;
        endcase
      end
      // Ready is checked before the timeout so a late ready still completes.
      ST_MEM: begin
        if (MemReady) begin
          state_d = (op3 == OP_SW) ? ST_FETCH : ST_WB;
        end else if (timeout_hit) begin
          state_d   = ST_HALT;
          mem_err_d = 1'b1;
        end
      end
      ST_WB:   state_d = ST_FETCH;
      ST_HALT: begin
        if (Resume) begin
          state_d   = ST_FETCH;
          illegal_d = 1'b0;
          mem_err_d = 1'b0;
        end
      end
      default: state_d = ST_START;
    endcase
  end

  assign halted_d = (state_d == ST_HALT);

  always_comb begin
    ctrl_d = '0;
    case (state_d)
      ST_FETCH: begin
        ctrl_d.ir_esc = 1'b1;
        // A store retires on the ready edge, so its PC write lands here.
        if (state_q == ST_MEM) ctrl_d.esc_pc = 1'b1;
      end
      ST_EXEC: begin
        case (op3)
          OP_ADD: begin
            ctrl_d.ula_op    = ULA_ADD;
            ctrl_d.ula_fonte = 1'b1;
          end
          OP_SLT: ctrl_d.ula_op = ULA_SLT;
          OP_BEQ: begin
            ctrl_d.ula_op = ULA_SUB;
            ctrl_d.branch = 1'b1;
            ctrl_d.esc_pc = 1'b1;
          end
          OP_JUMP: begin
            ctrl_d.jump   = 1'b1;
            ctrl_d.esc_pc = 1'b1;
          end
          OP_SW, OP_LW: begin
            ctrl_d.ula_op    = ULA_ADD;
            ctrl_d.ula_fonte = 1'b1;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        if (op3 == OP_SW) ctrl_d.esc_mem = 1'b1;
        else              ctrl_d.ler_mem = 1'b1;
      end
      ST_WB: begin
        ctrl_d.esc_reg = 1'b1;
        ctrl_d.esc_pc  = 1'b1;
        case (op3)
          OP_ADD, OP_SLT: ctrl_d.reg_dest   = 1'b1;
          OP_MOVE:        ctrl_d.move_reg   = 1'b1;
          OP_LW:          ctrl_d.mem_to_reg = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  generate
    if (MEM_TIMEOUT > 0) begin : g_timeout
      localparam int unsigned    CW   = $clog2(MEM_TIMEOUT + 1);
      localparam logic [CW-1:0]  LAST = CW'(MEM_TIMEOUT - 1);
      logic [CW-1:0] cnt_q, cnt_d;

      always_comb begin
        cnt_d = (state_q == ST_MEM && state_d == ST_MEM) ? cnt_q + 1'b1 : '0;
      end

      always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) cnt_q <= '0;
        else         cnt_q <= cnt_d;
      end

      assign timeout_hit = (cnt_q == LAST);
    end else begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end
  endgenerate

  // armed_q holds START for one extra edge after reset release.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q   <= ST_START;
      op_q      <= '0;
      armed_q   <= 1'b0;
      ctrl_q    <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      armed_q   <= armed_d;
      ctrl_q    <= ctrl_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign IREsc     = ctrl_q.ir_esc;
  assign MemToReg  = ctrl_q.mem_to_reg;
  assign EscMem    = ctrl_q.esc_mem;
  assign LerMem    = ctrl_q.ler_mem;
  assign Branch    = ctrl_q.branch;
  assign ULAFonte  = ctrl_q.ula_fonte;
  assign EscReg    = ctrl_q.esc_reg;
  assign Jump      = ctrl_q.jump;
  assign EscPc     = ctrl_q.esc_pc;
  assign MoveReg   = ctrl_q.move_reg;
  assign RegDest   = ctrl_q.reg_dest;
  assign ULAOp     = ctrl_q.ula_op;
  assign State     = state_q;
  assign Halted    = halted_q;
  assign IllegalOp = illegal_q;
  assign MemErr    = mem_err_q;

endmodule

// File: tb/tb_ctrl_multiciclo.sv
// Bench for ctrl_multiciclo: each instruction is expanded into the expected
// per-cycle trace of state, controls and flags, then stepped and compared.
module tb_ctrl_multiciclo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] opcode;
  logic       mem_ready, resume;
  logic       MemToReg, EscMem, LerMem, Branch, ULAFonte, EscReg, Jump, EscPc;
  logic       MoveReg, RegDest, IREsc, Halted, IllegalOp, MemErr;
  logic [1:0] ULAOp;
  logic [2:0] State;

  int unsigned checks = 0;
  int unsigned errors = 0;

  ctrl_multiciclo #(.OP_W(4), .MEM_TIMEOUT(15)) dut (
    .Clock(clk), .ResetN(rst_n), .OPcode(opcode), .MemReady(mem_ready), .Resume(resume),
    .MemToReg(MemToReg), .EscMem(EscMem), .LerMem(LerMem), .Branch(Branch),
    .ULAFonte(ULAFonte), .EscReg(EscReg), .Jump(Jump), .EscPc(EscPc),
    .MoveReg(MoveReg), .RegDest(RegDest), .ULAOp(ULAOp), .IREsc(IREsc),
    .State(State), .Halted(Halted), .IllegalOp(IllegalOp), .MemErr(MemErr)
  );

  always #5 clk = ~clk;

  // Control vector: IREsc MemToReg EscMem LerMem Branch ULAFonte EscReg Jump EscPc MoveReg RegDest ULAOp[1:0]
  localparam logic [12:0] B_IR = 13'h1000, B_M2R = 13'h0800, B_WMEM = 13'h0400, B_RMEM = 13'h0200;
  localparam logic [12:0] B_BR = 13'h0100, B_SRC = 13'h0080, B_WREG = 13'h0040, B_JMP = 13'h0020;
  localparam logic [12:0] B_PC = 13'h0010, B_MOV = 13'h0008, B_RD = 13'h0004;
  localparam logic [12:0] U_SUB = 13'h0001, U_SLT = 13'h0002;
  // Flags: {Halted, IllegalOp, MemErr}
  localparam logic [2:0] F_NONE = 3'b000, F_HALT = 3'b100, F_ILL = 3'b110, F_MERR = 3'b101;

  logic [12:0] obs_ctl;
  logic [2:0]  obs_flags;
  assign obs_ctl   = {IREsc, MemToReg, EscMem, LerMem, Branch, ULAFonte, EscReg, Jump, EscPc,
                      MoveReg, RegDest, ULAOp};
  assign obs_flags = {Halted, IllegalOp, MemErr};

  typedef struct {
    logic [2:0]  st;
    logic [12:0] ctl;
    logic [2:0]  fl;
    logic        care;
    logic        rdy;
  } step_t;

  step_t trace[$];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_now(input string tag, input logic [2:0] st, input logic [12:0] ctl,
                            input logic [2:0] fl);
    check({tag, "_state"}, 16'(State), 16'(st));
    check({tag, "_ctl"}, 16'(obs_ctl), 16'(ctl));
    check({tag, "_flags"}, 16'(obs_flags), 16'(fl));
  endtask

  task automatic push(input logic [2:0] st, input logic [12:0] ctl, input logic [2:0] fl,
                      input logic care, input logic rdy);
    step_t s;
    s.st = st; s.ctl = ctl; s.fl = fl; s.care = care; s.rdy = rdy;
    trace.push_back(s);
  endtask

  // Expected trace after FETCH entry. waits < 0 means memory never answers.
  task automatic build(input logic [3:0] op, input int waits);
    logic [2:0]  o;
    logic [12:0] strobe;
    o = op[2:0];
    trace.delete();
    push(3'd2, '0, F_NONE, 1'b0, 1'b0);
    if (op[3]) begin
      push(3'd6, '0, F_ILL, 1'b0, 1'b0);
      return;
    end
    if (o == 3'd7) begin
      push(3'd6, '0, F_HALT, 1'b0, 1'b0);
      return;
    end
    case (o)
      3'd0:       push(3'd3, B_SRC, F_NONE, 1'b0, 1'b0);
      3'd1:       push(3'd3, '0, F_NONE, 1'b0, 1'b0);
      3'd2:       push(3'd3, U_SLT, F_NONE, 1'b0, 1'b0);
      3'd3:       push(3'd3, U_SUB | B_BR | B_PC, F_NONE, 1'b0, 1'b0);
      3'd4:       push(3'd3, B_JMP | B_PC, F_NONE, 1'b0, 1'b0);
      default:    push(3'd3, B_SRC, F_NONE, 1'b0, 1'b0);
    endcase
    if (o == 3'd3 || o == 3'd4) begin
      push(3'd1, B_IR, F_NONE, 1'b0, 1'b0);
      return;
    end
    if (o == 3'd5 || o == 3'd6) begin
      strobe = (o == 3'd5) ? B_WMEM : B_RMEM;
      push(3'd4, strobe, F_NONE, 1'b0, 1'b0);
      if (waits < 0) begin
        for (int i = 1; i < 15; i++) push(3'd4, strobe, F_NONE, 1'b1, 1'b0);
        push(3'd6, '0, F_MERR, 1'b1, 1'b0);
        return;
      end
      for (int i = 0; i < waits; i++) push(3'd4, strobe, F_NONE, 1'b1, 1'b0);
      if (o == 3'd5) begin
        push(3'd1, B_IR | B_PC, F_NONE, 1'b1, 1'b1);
        return;
      end
      push(3'd5, B_WREG | B_PC | B_M2R, F_NONE, 1'b1, 1'b1);
    end else if (o == 3'd1) begin
      push(3'd5, B_WREG | B_PC | B_MOV, F_NONE, 1'b0, 1'b0);
    end else begin
      push(3'd5, B_WREG | B_PC | B_RD, F_NONE, 1'b0, 1'b0);
    end
    push(3'd1, B_IR, F_NONE, 1'b0, 1'b0);
  endtask

  // Steps through at most 'limit' entries of the trace; OPcode is valid only in DECODE.
  task automatic run_trace(input logic [3:0] op, input int limit);
    for (int k = 0; k < trace.size() && k < limit; k++) begin
      @(negedge clk);
      opcode    = (k == 1) ? op : 4'($urandom);
      mem_ready = trace[k].care ? trace[k].rdy : 1'($urandom);
      resume    = 1'($urandom);
      @(posedge clk); #1;
      expect_now($sformatf("op%h_s%0d", op, k), trace[k].st, trace[k].ctl, trace[k].fl);
    end
  endtask

  task automatic halt_resume(input logic [2:0] fl, input int hold);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      resume = 1'b0; mem_ready = 1'($urandom); opcode = 4'($urandom);
      @(posedge clk); #1;
      expect_now("halt_hold", 3'd6, '0, fl);
    end
    @(negedge clk);
    resume = 1'b1;
    @(posedge clk); #1;
    expect_now("resume", 3'd1, B_IR, F_NONE);
  endtask

  task automatic run_instr(input logic [3:0] op, input int waits);
    build(op, waits);
    run_trace(op, trace.size());
    if (trace[trace.size()-1].st == 3'd6)
      halt_resume(trace[trace.size()-1].fl, int'($urandom_range(0, 3)));
  endtask

  task automatic do_reset_release();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    expect_now("rel_edge1", 3'd0, '0, F_NONE);
    @(posedge clk); #1;
    expect_now("rel_edge2", 3'd1, B_IR, F_NONE);
  endtask

  initial begin
    logic [3:0] rop;
    int         rw;
    rst_n = 1'b0; opcode = '0; mem_ready = 1'b0; resume = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    expect_now("reset", 3'd0, '0, F_NONE);
    do_reset_release();

    run_instr(4'h0, 0);
    run_instr(4'h6, 3);
    run_instr(4'h5, -1);
    run_instr(4'h3, 0);
    run_instr(4'h4, 0);
    run_instr(4'h8, 0);
    run_instr(4'h7, 0);
    run_instr(4'h6, 14);
    run_instr(4'h5, 0);
    run_instr(4'h6, -1);
    run_instr(4'h1, 0);
    run_instr(4'h2, 0);
    run_instr(4'hD, 0);

    for (int n = 0; n < 60; n++) begin
      rop = (($urandom_range(0, 9)) < 8) ? {1'b0, 3'($urandom)} : {1'b1, 3'($urandom)};
      rw  = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 14));
      run_instr(rop, rw);
    end

    // Abort a pending load mid-cycle, then restart cleanly.
    build(4'h6, 10);
    run_trace(4'h6, 5);
    check("mid_lerm", 16'(LerMem), 16'd1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    expect_now("async_rst", 3'd0, '0, F_NONE);
    @(posedge clk); #1;
    expect_now("rst_hold", 3'd0, '0, F_NONE);
    do_reset_release();
    run_instr(4'h0, 0);
    run_instr(4'h6, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
